board_ctl: RTL and testbench

//  Game-state controller for the 3x3 tic-tac-toe board; sits directly upstream of the
//  per-square draw stages (square1..9). Takes mouse clicks, maps them to a square, marks

---
 rtl/board_ctl_pkg.sv | 55 +++++
 rtl/board_ctl_if.sv | 24 ++
 rtl/board_ctl_click_decode.sv | 24 ++
 rtl/board_ctl.sv | 161 ++++++++++++++++
 tb/tb_board_ctl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_ctl_pkg.sv
// Shared constants and types for the tic-tac-toe board controller.
package board_ctl_pkg;

    // Grid boundaries (inclusive), in pixels.
    localparam logic [11:0] C1_END = 12'd339;
    localparam logic [11:0] C2_BEG = 12'd343;
    localparam logic [11:0] C2_END = 12'd681;
    localparam logic [11:0] C3_BEG = 12'd685;
    localparam logic [11:0] C3_END = 12'd1023;
    localparam logic [11:0] R1_END = 12'd251;
    localparam logic [11:0] R2_BEG = 12'd258;
    localparam logic [11:0] R2_END = 12'd509;
    localparam logic [11:0] R3_BEG = 12'd516;
    localparam logic [11:0] R3_END = 12'd767;

    // Colour words handed to the square draw stages.
    localparam logic [11:0] P0_COLOR = 12'h000;
    localparam logic [11:0] P1_COLOR = 12'hff0;

    // Winner encodings.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Square index meaning "not on any square".
    localparam logic [3:0] IDX_NONE = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StUpdate,
        StCheck
    } state_e;

    // Map one coordinate to a band 0..2, or 3 when it falls in a gap or past the grid.
    function automatic logic [1:0] coord_band(
        input logic [11:0] v,
        input logic [11:0] end0,
        input logic [11:0] beg1,
        input logic [11:0] end1,
        input logic [11:0] beg2,
        input logic [11:0] end2
    );
        if (v <= end0) begin
            return 2'd0;
        end else if (v >= beg1 && v <= end1) begin
            return 2'd1;
        end else if (v >= beg2 && v <= end2) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/board_ctl_if.sv
// Mouse/control inputs and board-state outputs of the board controller.
interface board_ctl_if;
    logic [11:0]  mouse_xpos;
    logic [11:0]  mouse_ypos;
    logic         mouse_left;
    logic         start_en;
    logic         choice_en;
    logic         new_game;
    logic [8:0]   square;
    logic [107:0] square_color;
    logic         turn;
    logic         game_over;
    logic [1:0]   winner;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        input  square, square_color, turn, game_over, winner
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        output square, square_color, turn, game_over, winner
    );
endinterface

// File: rtl/board_ctl_click_decode.sv
// Combinational mapping of a pixel position to a square index (row-major, IDX_NONE = off-grid).
module click_decode
    import board_ctl_pkg::*;
(
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [3:0]  idx
);

    logic [1:0] col;
    logic [1:0] row;

    // Column/row band lookup, then combine into a 0..8 index.
    always_comb begin
        col = coord_band(xpos, C1_END, C2_BEG, C2_END, C3_BEG, C3_END);
        row = coord_band(ypos, R1_END, R2_BEG, R2_END, R3_BEG, R3_END);
        if (col == 2'd3 || row == 2'd3) begin
            idx = IDX_NONE;
        end else begin
            idx = {2'b00, row} * 4'd3 + {2'b00, col};
        end
    end

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe game-state controller: click capture, square marking, turn and win/draw tracking.
module board_ctl
    import board_ctl_pkg::*;
(
    input logic        pclk,
    input logic        rst,
    board_ctl_if.slave bus
);

    // One mask per line: 3 rows, 3 columns, 2 diagonals (bit k = square k+1).
    localparam logic [7:0][8:0] LINE_MASK = {
        9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
    };

    state_e      state_q, state_d;
    logic        left_q;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  square_q, square_d;
    logic [8:0]  owner_q, owner_d;   // 1 = player 1 owns the square
    logic        turn_q, turn_d;
    logic        over_q, over_d;
    logic [1:0]  winner_q, winner_d;

    logic        click;
    logic        play_en;
    logic [3:0]  dec_idx;
    logic        win0;
    logic        win1;
    logic [107:0] color;

    assign play_en = bus.start_en & ~bus.choice_en;
    assign click   = bus.mouse_left & ~left_q;

    click_decode u_click_decode (
        .xpos (x_q),
        .ypos (y_q),
        .idx  (dec_idx)
    );

    // Button history for rising-edge detection; a held button yields one click.
    always_ff @(posedge pclk) begin
        if (rst) begin
            left_q <= 1'b0;
        end else begin
            left_q <= bus.mouse_left;
        end
    end

    // Line ownership on the registered board.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if ((square_q & ~owner_q & LINE_MASK[l]) == LINE_MASK[l]) win0 = 1'b1;
            if ((square_q & owner_q & LINE_MASK[l]) == LINE_MASK[l]) win1 = 1'b1;
        end
    end

    // FSM next-state and board update; new_game overrides everything else.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        idx_d    = idx_q;
        square_d = square_q;
        owner_d  = owner_q;
        turn_d   = turn_q;
        over_d   = over_q;
        winner_d = winner_q;

        unique case (state_q)
            StIdle: begin
                if (click && play_en && !over_q) begin
                    x_d     = bus.mouse_xpos;
                    y_d     = bus.mouse_ypos;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                idx_d   = dec_idx;
                state_d = StUpdate;
            end
            StUpdate: begin
                for (int k = 0; k < 9; k++) begin
                    if (idx_q == 4'(k) && !square_q[k]) begin
                        square_d[k] = 1'b1;
                        owner_d[k]  = turn_q;
                        turn_d      = ~turn_q;
                    end
                end
                state_d = StCheck;
            end
            StCheck: begin
                // A completed line wins even when it is also the ninth move.
                if (win0) begin
                    over_d   = 1'b1;
                    winner_d = WIN_P0;
                end else if (win1) begin
                    over_d   = 1'b1;
                    winner_d = WIN_P1;
                end else if (&square_q) begin
                    over_d   = 1'b1;
                    winner_d = WIN_DRAW;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.new_game) begin
            state_d  = StIdle;
            square_d = '0;
            owner_d  = '0;
            turn_d   = 1'b0;
            over_d   = 1'b0;
            winner_d = WIN_NONE;
        end
    end

    // State registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= IDX_NONE;
            square_q <= '0;
            owner_q  <= '0;
            turn_q   <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            square_q <= square_d;
            owner_q  <= owner_d;
            turn_q   <= turn_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    // Per-square colour words; empty squares read as zero.
    always_comb begin
        color = '0;
        for (int k = 0; k < 9; k++) begin
            if (square_q[k]) color[12*k +: 12] = owner_q[k] ? P1_COLOR : P0_COLOR;
        end
    end

    assign bus.square       = square_q;
    assign bus.square_color = color;
    assign bus.turn         = turn_q;
    assign bus.game_over    = over_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_board_ctl.sv
// Self-checking bench for board_ctl: directed scenarios plus randomized clicks vs a board model.
module tb_board_ctl;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    always #5 pclk = ~pclk;

    board_ctl_if bus ();

    board_ctl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 empty, 1 player 0, 2 player 1.
    int       brd [9];
    bit       m_turn;
    bit       m_over;
    logic [1:0] m_win;
    int       lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                               '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    function automatic int band(int v, int e0, int b1, int e1, int b2, int e2);
        if (v >= 0 && v <= e0) return 0;
        if (v >= b1 && v <= e1) return 1;
        if (v >= b2 && v <= e2) return 2;
        return -1;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 9; k++) brd[k] = 0;
        m_turn = 1'b0;
        m_over = 1'b0;
        m_win  = 2'b00;
    endfunction

    function automatic logic [8:0] m_square();
        logic [8:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s[k] = (brd[k] != 0);
        return s;
    endfunction

    function automatic logic [107:0] m_color();
        logic [107:0] c;
        c = '0;
        for (int k = 0; k < 9; k++) if (brd[k] == 2) c[12*k +: 12] = 12'hff0;
        return c;
    endfunction

    // One accepted click: place a mark if legal, then score the board.
    function automatic void m_apply(int x, int y);
        int col;
        int row;
        int full;
        col = band(x, 339, 343, 681, 685, 1023);
        row = band(y, 251, 258, 509, 516, 767);
        if (col >= 0 && row >= 0 && brd[row*3+col] == 0) begin
            brd[row*3+col] = m_turn ? 2 : 1;
            m_turn = ~m_turn;
        end
        for (int l = 0; l < 8; l++) begin
            if (!m_over && brd[lines[l][0]] != 0 && brd[lines[l][0]] == brd[lines[l][1]] &&
                brd[lines[l][1]] == brd[lines[l][2]]) begin
                m_over = 1'b1;
                m_win  = (brd[lines[l][0]] == 1) ? 2'b01 : 2'b10;
            end
        end
        full = 1;
        for (int k = 0; k < 9; k++) if (brd[k] == 0) full = 0;
        if (!m_over && full == 1) begin
            m_over = 1'b1;
            m_win  = 2'b11;
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_sq"}, 128'(bus.square), 128'(m_square()));
        chk({tag, "_col"}, 128'(bus.square_color), 128'(m_color()));
        chk({tag, "_turn"}, 128'(bus.turn), 128'(m_turn));
        chk({tag, "_over"}, 128'(bus.game_over), 128'(m_over));
        chk({tag, "_win"}, 128'(bus.winner), 128'(m_win));
    endtask

    function automatic int cx(int c);
        case (c)
            0: return 170;
            1: return 512;
            default: return 854;
        endcase
    endfunction

    function automatic int cy(int r);
        case (r)
            0: return 125;
            1: return 383;
            default: return 641;
        endcase
    endfunction

    // Press at a negedge, release after edge N, check N+1 (unchanged), N+2 (board), N+3 (result).
    task automatic do_click(input string tag, input int x, input int y);
        logic [8:0] sq0;
        bit         act;
        sq0 = m_square();
        act = bus.start_en && !bus.choice_en && !m_over;
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        bus.mouse_left = 1'b0;
        @(negedge pclk);
        chk({tag, "_n1"}, 128'(bus.square), 128'(sq0));
        if (act) m_apply(x, y);
        @(negedge pclk);
        chk({tag, "_sq"}, 128'(bus.square), 128'(m_square()));
        chk({tag, "_col"}, 128'(bus.square_color), 128'(m_color()));
        chk({tag, "_turn"}, 128'(bus.turn), 128'(m_turn));
        @(negedge pclk);
        chk({tag, "_over"}, 128'(bus.game_over), 128'(m_over));
        chk({tag, "_win"}, 128'(bus.winner), 128'(m_win));
    endtask

    task automatic click_idx(input string tag, input int i);
        do_click(tag, cx(i % 3), cy(i / 3));
    endtask

    task automatic pulse_new_game(input string tag);
        bus.new_game = 1'b1;
        @(negedge pclk);
        bus.new_game = 1'b0;
        m_reset();
        chk_all(tag);
    endtask

    function automatic int pick_coord(int sel, int lim);
        case (sel)
            0: return 0;
            1: return 339;
            2: return 340;
            3: return 342;
            4: return 343;
            5: return 681;
            6: return 685;
            7: return 1023;
            8: return 1024;
            9: return 4095;
            10: return 251;
            11: return 252;
            12: return 258;
            13: return 767;
            14: return 768;
            default: return int'($urandom_range(0, lim));
        endcase
    endfunction

    initial begin
        int ord [9] = '{0, 2, 1, 3, 5, 4, 6, 8, 7};
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        bus.mouse_left = 1'b0;
        bus.start_en   = 1'b1;
        bus.choice_en  = 1'b0;
        bus.new_game   = 1'b0;
        m_reset();

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        chk_all("reset");
        rst = 1'b0;
        @(negedge pclk);

        // 1: top-right square for player 0.
        do_click("t1", 700, 100);
        chk("t1_sq_lit", 128'(bus.square), 128'(9'h004));
        chk("t1_col_lit", 128'(bus.square_color[35:24]), 128'(12'h000));
        chk("t1_turn_lit", 128'(bus.turn), 128'(1'b1));

        // 2: gap click ignored, repeat click on occupied square ignored.
        pulse_new_game("t2_ng");
        do_click("t2_gap", 341, 100);
        do_click("t2_a", 100, 100);
        do_click("t2_b", 100, 100);
        chk("t2_sq_lit", 128'(bus.square), 128'(9'h001));
        chk("t2_turn_lit", 128'(bus.turn), 128'(1'b1));

        // Held button counts once.
        bus.mouse_xpos = 12'd512;
        bus.mouse_ypos = 12'd383;
        bus.mouse_left = 1'b1;
        repeat (10) @(negedge pclk);
        bus.mouse_left = 1'b0;
        repeat (2) @(negedge pclk);
        m_apply(512, 383);
        chk_all("held");

        // 3: player 0 takes the top row; board then frozen.
        pulse_new_game("t3_ng");
        click_idx("t3_m0", 0);
        click_idx("t3_m1", 3);
        click_idx("t3_m2", 1);
        click_idx("t3_m3", 4);
        click_idx("t3_m4", 2);
        chk("t3_win_lit", 128'(bus.winner), 128'(2'b01));
        do_click("t3_after", 100, 600);

        // 4: full board with no line.
        pulse_new_game("t4_ng");
        for (int i = 0; i < 9; i++) click_idx("t4_m", ord[i]);
        chk("t4_win_lit", 128'(bus.winner), 128'(2'b11));
        chk("t4_sq_lit", 128'(bus.square), 128'(9'h1FF));

        // 5: play blocked by menu or inactive screen; new_game beats a click.
        pulse_new_game("t5_ng");
        bus.choice_en = 1'b1;
        do_click("t5_choice", 700, 100);
        bus.choice_en = 1'b0;
        bus.start_en  = 1'b0;
        do_click("t5_start", 700, 100);
        bus.start_en  = 1'b1;
        do_click("t5_play", 700, 100);
        bus.mouse_xpos = 12'd100;
        bus.mouse_ypos = 12'd100;
        bus.mouse_left = 1'b1;
        bus.new_game   = 1'b1;
        @(negedge pclk);
        bus.mouse_left = 1'b0;
        bus.new_game   = 1'b0;
        m_reset();
        repeat (3) @(negedge pclk);
        chk_all("t5_ngclick");

        // 6: reset between UPDATE and CHECK, then a normal click.
        click_idx("t6_pre", 0);
        bus.mouse_xpos = 12'd512;
        bus.mouse_ypos = 12'd383;
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        bus.mouse_left = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        m_apply(512, 383);
        chk("t6_upd", 128'(bus.square), 128'(m_square()));
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        m_reset();
        chk_all("t6_rst");
        click_idx("t6_post", 8);

        // Randomized play against the model.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0 || (m_over && $urandom_range(0, 2) == 0)) begin
                pulse_new_game("r_ng");
            end
            bus.start_en  = ($urandom_range(0, 9) != 0);
            bus.choice_en = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                click_idx("r_cell", int'($urandom_range(0, 8)));
            end else begin
                do_click("r_xy", pick_coord(int'($urandom_range(0, 24)), 1100),
                         pick_coord(int'($urandom_range(0, 24)), 800));
            end
        end
        bus.start_en  = 1'b1;
        bus.choice_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
